regfile_param: RTL and testbench

Parametrised successor to the fixed 32 x 64 register file. It provides DEPTH = 2^ADDR_WIDTH registers of DATA_WIDTH bits, with two combinational read ports and one synchronous write port. New features:
- optional hardwired zero register
- optional write-to-read bypass
- sequenced bulk-clear engine with busy/done handshake

Sits in the datapath between decode (select_a/select_b) and the ALU/writeback stage.

---
 rtl/regfile_param.sv | 101 ++++++++++
 tb/tb_regfile_param.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// Parametrised register file: two combinational read ports, one synchronous write port,
// optional hardwired zero register, optional write-to-read bypass and a sequenced bulk clear.
module regfile_param #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter bit          ZERO_EN    = 1'b1,
  parameter int unsigned ZERO_IDX   = 31,
  parameter bit          BYPASS_EN  = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] select_a,
  input  logic [ADDR_WIDTH-1:0] select_b,
  output logic [DATA_WIDTH-1:0] out_a,
  output logic [DATA_WIDTH-1:0] out_b,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  write,
  input  logic                  clear,
  output logic                  busy,
  output logic                  clear_done
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_IDX);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] count, count_nxt;
  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  write_ok;

  // Writes only land while idle, and never on the hardwired zero register.
  assign write_ok = (state == ST_IDLE) && write && !(ZERO_EN && (address == ZERO_ADDR));

  // Next-state logic of the clear sequencer.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      ST_IDLE: begin
        if (clear) begin
          state_nxt = ST_CLEAR;
          count_nxt = '0;
        end
      end
      ST_CLEAR: begin
        count_nxt = count + ADDR_WIDTH'(1);
        if (count == LAST_ADDR) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, counter and handshake flops; handshake decoded from next state so it tracks the state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      count      <= '0;
      busy       <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      busy       <= (state_nxt == ST_CLEAR);
      clear_done <= (state_nxt == ST_DONE);
    end
  end

  // Register array: normal writes while idle, one entry zeroed per cycle while clearing.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (write_ok) regs[address] <= data_in;
      if (state == ST_CLEAR) regs[count] <= '0;
    end
  end

  // Read port A: array, then bypass, then zero-register override.
  always_comb begin
    out_a = regs[select_a];
    if (BYPASS_EN && write_ok && (address == select_a)) out_a = data_in;
    if (ZERO_EN && (select_a == ZERO_ADDR)) out_a = '0;
  end

  // Read port B: same priority as port A.
  always_comb begin
    out_b = regs[select_b];
    if (BYPASS_EN && write_ok && (address == select_b)) out_b = data_in;
    if (ZERO_EN && (select_b == ZERO_ADDR)) out_b = '0;
  end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: one instance with bypass, one without, sharing all inputs.
module tb_regfile_param;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  sel_a, sel_b, address;
  logic [63:0] data_in;
  logic        write, clear;
  logic [63:0] out_a0, out_b0, out_a1, out_b1;
  logic        busy0, done0, busy1, done1;

  int checks = 0;
  int errors = 0;

  regfile_param #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .ZERO_EN(1'b1), .ZERO_IDX(31), .BYPASS_EN(1'b1)) dut0 (
    .clock(clock), .reset(reset), .select_a(sel_a), .select_b(sel_b),
    .out_a(out_a0), .out_b(out_b0), .address(address), .data_in(data_in),
    .write(write), .clear(clear), .busy(busy0), .clear_done(done0)
  );

  regfile_param #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .ZERO_EN(1'b1), .ZERO_IDX(31), .BYPASS_EN(1'b0)) dut1 (
    .clock(clock), .reset(reset), .select_a(sel_a), .select_b(sel_b),
    .out_a(out_a1), .out_b(out_b1), .address(address), .data_in(data_in),
    .write(write), .clear(clear), .busy(busy1), .clear_done(done1)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [63:0] din;
    logic [4:0]  sa;
    logic [63:0] a0;
    logic [63:0] a1;
    logic [4:0]  sb;
    logic [63:0] b0;
    logic [63:0] b1;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every register reads zero on both ports of both instances.
  task automatic sweep_zero(input string name);
    for (int i = 0; i < 32; i++) begin
      @(negedge clock);
      write = 1'b0; clear = 1'b0;
      sel_a = 5'(i); sel_b = 5'(31 - i);
      #1;
      check({name, "_a0"}, out_a0, 64'h0);
      check({name, "_b0"}, out_b0, 64'h0);
      check({name, "_a1"}, out_a1, 64'h0);
      check({name, "_b1"}, out_b1, 64'h0);
    end
  endtask

  // Write index+1 into every register (reg 31 write must be discarded).
  task automatic fill;
    for (int i = 0; i < 32; i++) begin
      @(negedge clock);
      write = 1'b1; address = 5'(i); data_in = 64'(i + 1);
    end
    @(negedge clock);
    write = 1'b0;
    sel_a = 5'd31; sel_b = 5'd30;
    #1;
    check("fill_zero_reg", out_a0, 64'h0);
    check("fill_reg30", out_b0, 64'd31);
  endtask

  // Full clear sequence; sample n is taken after the n-th edge following the clear edge.
  task automatic clear_seq(input bit collide);
    logic [63:0] ea, eb;
    @(negedge clock);
    clear = 1'b1; write = 1'b0;
    sel_a = collide ? 5'd30 : 5'd3;
    sel_b = collide ? 5'd2 : 5'd20;
    for (int n = 1; n <= 35; n++) begin
      @(negedge clock);
      clear = 1'b0; write = 1'b0;
      if (collide && n == 5)  begin write = 1'b1; address = 5'd30; data_in = 64'hFF; clear = 1'b1; end
      if (collide && n == 6)  begin write = 1'b1; address = 5'd2;  data_in = 64'h55; end
      if (collide && n == 33) begin write = 1'b1; address = 5'd1;  data_in = 64'h77; clear = 1'b1; end
      #1;
      ea = (int'(sel_a) <= n - 2) ? 64'h0 : 64'(sel_a) + 64'd1;
      eb = (int'(sel_b) <= n - 2) ? 64'h0 : 64'(sel_b) + 64'd1;
      check("clr_busy", 64'(busy0), 64'(n <= 32));
      check("clr_done", 64'(done0), 64'(n == 33));
      check("clr_rd_a", out_a0, ea);
      check("clr_rd_b", out_b0, eb);
    end
    write = 1'b0;
    sweep_zero(collide ? "coll_end" : "clr_end");
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd5,  64'hDEADBEEF_CAFEF00D, 5'd5,  64'hDEADBEEF_CAFEF00D, 64'h0,
                5'd5,  64'hDEADBEEF_CAFEF00D, 64'h0};
    vecs[1] = '{1'b0, 5'd0,  64'h0, 5'd5,  64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D,
                5'd5,  64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D};
    vecs[2] = '{1'b1, 5'd31, 64'h1, 5'd31, 64'h0, 64'h0,
                5'd5,  64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D};
    vecs[3] = '{1'b0, 5'd0,  64'h0, 5'd31, 64'h0, 64'h0, 5'd31, 64'h0, 64'h0};
    vecs[4] = '{1'b1, 5'd7,  64'h10, 5'd7, 64'h10, 64'h0, 5'd0, 64'h0, 64'h0};
    vecs[5] = '{1'b1, 5'd7,  64'h20, 5'd7, 64'h20, 64'h10, 5'd7, 64'h20, 64'h10};
    vecs[6] = '{1'b0, 5'd0,  64'h0, 5'd7,  64'h20, 64'h20,
                5'd5,  64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D};
    vecs[7] = '{1'b1, 5'd0,  64'hAA, 5'd0, 64'hAA, 64'h0, 5'd7, 64'h20, 64'h20};
    vecs[8] = '{1'b0, 5'd0,  64'h0, 5'd0,  64'hAA, 64'hAA, 5'd0, 64'hAA, 64'hAA};

    reset = 1'b0; write = 1'b0; clear = 1'b0;
    sel_a = '0; sel_b = '0; address = '0; data_in = '0;

    // Reset held for two cycles
    repeat (2) @(negedge clock);
    #1;
    check("rst_busy", 64'(busy0), 64'h0);
    check("rst_done", 64'(done0), 64'h0);
    @(negedge clock);
    reset = 1'b1;
    sweep_zero("reset");

    // Table-driven write/read/bypass vectors
    for (int v = 0; v < 9; v++) begin
      @(negedge clock);
      write = vecs[v].wr; address = vecs[v].addr; data_in = vecs[v].din;
      sel_a = vecs[v].sa; sel_b = vecs[v].sb;
      #1;
      check($sformatf("vec%0d_a0", v), out_a0, vecs[v].a0);
      check($sformatf("vec%0d_b0", v), out_b0, vecs[v].b0);
      check($sformatf("vec%0d_a1", v), out_a1, vecs[v].a1);
      check($sformatf("vec%0d_b1", v), out_b1, vecs[v].b1);
      check($sformatf("vec%0d_busy", v), 64'(busy0 | done0 | busy1 | done1), 64'h0);
    end

    // Plain clear sequence, then clear with write/clear collisions
    fill();
    clear_seq(1'b0);
    fill();
    clear_seq(1'b1);

    // Reset in the middle of a clear sequence
    fill();
    @(negedge clock);
    clear = 1'b1; sel_a = 5'd20; sel_b = 5'd25;
    for (int n = 1; n <= 11; n++) begin
      @(negedge clock);
      clear = 1'b0;
    end
    #1;
    check("pre_abort_busy", 64'(busy0), 64'h1);
    check("pre_abort_rd", out_a0, 64'd21);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort_busy", 64'(busy0), 64'h0);
    check("abort_done", 64'(done0), 64'h0);
    check("abort_rd", out_a0, 64'h0);
    @(negedge clock);
    reset = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clock);
      #1;
      check("post_abort_busy", 64'(busy0), 64'h0);
      check("post_abort_done", 64'(done0), 64'h0);
    end
    sweep_zero("abort");
    @(negedge clock);
    write = 1'b1; address = 5'd2; data_in = 64'h1234; sel_a = 5'd2; sel_b = 5'd2;
    @(negedge clock);
    write = 1'b0;
    #1;
    check("post_abort_wr_a", out_a0, 64'h1234);
    check("post_abort_wr_b", out_b1, 64'h1234);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
